mac_kbd_link: RTL and testbench
===============================

// Module: mac_kbd_link
// PURPOSE
//  Sequences the Mac keyboard serial link between the VIA shift-register lines (CB1 clock, CB2 data) and the PS/2 keyboard translator.
//  Only the Mac initiates: it sends an 8-bit command, then the block returns one 8-bit response.
//  Generates the keyboard clock, shifts both directions and inserts a NULL reply if the translator stays silent.
//  Sits in the data controller between via6522 and ps2_kbd, replacing the inline kbd logic.
// PARAMETERS
//  HALF_PERIOD   1300     clk8_en_p ticks per kbdclk half-period (~160us at 8.125 MHz)
//  RESP_TIMEOUT  2031250  ticks in WAIT_RESP before NULL reply (~250 ms)
//  NULL_RESP     8'h7B    byte sent on timeout
// PORTS
//  clk32          in   1  system clock, 32.5 MHz
//  _reset         in   1  asynchronous, active-low reset
//  clk8_en_p      in   1  8 MHz tick enable; all state advances only on this
//  cb2_o          in   1  VIA CB2 output value
//  cb2_t          in   1  VIA CB2 output enable; line = ~cb2_t | cb2_o (pulled high)
//  kbdclk         out  1  keyboard clock to VIA CB1
//  kbddata_o      out  1  keyboard data to VIA CB2 input
//  kbd_out_data   out  8  command byte received from the Mac, MSB first
//  kbd_out_strobe out  1  1-tick pulse: kbd_out_data valid
//  kbd_in_data    in   8  response byte from the translator
//  kbd_in_strobe  in   1  1-tick pulse: kbd_in_data valid
//  resp_drop      out  1  1-tick pulse: kbd_in_strobe arrived during RESP_TX and was discarded
//  busy           out  1  state != IDLE
// BEHAVIOUR
//  Reset values: state IDLE, kbdclk=1, kbddata_o=1, kbd_out_data=0, strobes=0, resp_valid=0, counters=0.
//  dat = ~cb2_t | cb2_o. Every rule below is evaluated only on ticks (clk8_en_p=1).
//  Clock generator: active in CMD_RX and RESP_TX. hcnt counts 0..HALF_PERIOD-1; at terminal count it clears and kbdclk toggles.
//    Otherwise hcnt=0 and kbdclk=1. One bit takes 2*HALF_PERIOD ticks; first edge is falling.
//  Response slot: on kbd_in_strobe outside RESP_TX, resp<=kbd_in_data and resp_valid<=1 (latest wins).
//    A strobe in RESP_TX is dropped and pulses resp_drop.
//  IDLE: dat==0 -> CMD_RX, bitcnt=0.
//  CMD_RX: at the tick that toggles kbdclk 1->0, shift kbd_out_data <= {kbd_out_data[6:0], dat}.
//    On each 0->1 toggle, bitcnt++. On the 8th rising edge, pulse kbd_out_strobe next tick -> WAIT_RESP, tcnt=0.
//  WAIT_RESP: kbdclk held 1. tcnt++ saturating.
//    dat==1 && resp_valid -> RESP_TX, bitcnt=0.
//    dat==1 && tcnt>=RESP_TIMEOUT -> load resp<=NULL_RESP, resp_valid=1, go RESP_TX in the same tick.
//    dat==0 here is ignored: Mac still holding line low.
//  RESP_TX: at each 1->0 toggle, kbddata_o <= resp[7-bitcnt]. On each 0->1 toggle, bitcnt++.
//    After the 8th rising edge, kbddata_o<=1, resp_valid<=0 -> IDLE.
//  Priority in one tick: reset > state transition > resp load. A strobe in the same tick as WAIT_RESP->RESP_TX is captured before transmission.
//  Mid-operation async reset aborts the frame: kbdclk/kbddata_o return high immediately, no strobe issued.
//  bitcnt is 3-bit with wrap; the 8th rising edge is detected as bitcnt==7 at that edge.
// STRUCTURE
//  Package mac_kbd_pkg: state enum {IDLE, CMD_RX, WAIT_RESP, RESP_TX}, NULL_RESP/INQUIRY constants.
//  One sub-module: mac_kbd_clkgen (hcnt, kbdclk, rise/fall tick pulses).
//  FSM and shifters stay in this file.
// TESTING  (HALF_PERIOD=4, RESP_TIMEOUT=200)
//  1. Mac drives 8'h10 MSB-first, data stable around falling edges.
//     -> kbd_out_strobe once, kbd_out_data=8'h10, after 8 rising edges (64 ticks).
//  2. Command 8'h14, kbd_in_strobe 8'hA5 before release, Mac releases line.
//     -> kbddata_o reproduces 1,0,1,0,0,1,0,1 on falling edges; then IDLE, kbddata_o=1.
//  3. Command, then silence, line released.
//     -> NULL 8'h7B transmitted starting exactly 200 ticks after WAIT_RESP entry.
//  4. Two kbd_in_strobes (8'h11 then 8'h22) before release -> 8'h22 sent.
//     Strobe during RESP_TX -> resp_drop pulse, byte in flight unchanged.
//  5. Assert _reset at bit 4 of CMD_RX -> kbdclk=1, kbddata_o=1, busy=0 same cycle.
//     No kbd_out_strobe; next frame decodes correctly.
//  6. clk8_en_p held low 100 cycles mid-frame -> no output change; frame resumes intact.

Source files
------------

// File: rtl/mac_kbd_pkg.sv
// Shared constants for the Mac keyboard link: FSM state encoding and protocol bytes.
package mac_kbd_pkg;

    typedef logic [1:0] kbd_state_t;

    localparam kbd_state_t ST_IDLE      = 2'd0;
    localparam kbd_state_t ST_CMD_RX    = 2'd1;
    localparam kbd_state_t ST_WAIT_RESP = 2'd2;
    localparam kbd_state_t ST_RESP_TX   = 2'd3;

    localparam logic [7:0] NULL_RESP = 8'h7B;
    localparam logic [7:0] INQUIRY   = 8'h10;

    // Responses leave MSB first, so bit slot n carries byte bit 7-n.
    function automatic logic resp_bit(input logic [7:0] b, input logic [2:0] slot);
        return b[3'd7 - slot];
    endfunction

endpackage

// File: rtl/mac_kbd_link_if.sv
// VIA shift-register lines plus translator handshake between the link and its neighbours.
interface mac_kbd_link_if;

    logic       cb2_o;
    logic       cb2_t;
    logic       kbdclk;
    logic       kbddata_o;
    logic [7:0] kbd_out_data;
    logic       kbd_out_strobe;
    logic [7:0] kbd_in_data;
    logic       kbd_in_strobe;
    logic       resp_drop;
    logic       busy;

    modport master (
        input  cb2_o,
        input  cb2_t,
        input  kbd_in_data,
        input  kbd_in_strobe,
        output kbdclk,
        output kbddata_o,
        output kbd_out_data,
        output kbd_out_strobe,
        output resp_drop,
        output busy
    );

    modport slave (
        output cb2_o,
        output cb2_t,
        output kbd_in_data,
        output kbd_in_strobe,
        input  kbdclk,
        input  kbddata_o,
        input  kbd_out_data,
        input  kbd_out_strobe,
        input  resp_drop,
        input  busy
    );

endinterface

// File: rtl/mac_kbd_clkgen.sv
// Keyboard clock generator: free-runs while active, otherwise parks high with the divider cleared.
module mac_kbd_clkgen #(
    parameter int HALF_PERIOD = 1300
) (
    input  logic clk32,
    input  logic _reset,
    input  logic clk8_en_p,
    input  logic active,
    output logic kbdclk,
    output logic rise_p,
    output logic fall_p
);

    localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HW-1:0] HCNT_LAST = HW'(HALF_PERIOD - 1);

    logic [HW-1:0] hcnt;
    logic          terminal;

    // Edge pulses coincide with the tick that toggles kbdclk, so the FSM can act on that same tick.
    assign terminal = clk8_en_p && active && (hcnt == HCNT_LAST);
    assign fall_p   = terminal && kbdclk;
    assign rise_p   = terminal && !kbdclk;

    always_ff @(posedge clk32 or negedge _reset) begin
        if (!_reset) begin
            hcnt   <= '0;
            kbdclk <= 1'b1;
        end else if (clk8_en_p) begin
            if (!active) begin
                hcnt   <= '0;
                kbdclk <= 1'b1;
            end else if (hcnt == HCNT_LAST) begin
                hcnt   <= '0;
                kbdclk <= ~kbdclk;
            end else begin
                hcnt <= hcnt + HW'(1);
            end
        end
    end

endmodule

// File: rtl/mac_kbd_link.sv
// Mac keyboard link sequencer: receives the Mac's command byte on CB1/CB2, then
// returns the translator's latest response, or NULL_RESP if the translator stays silent.
module mac_kbd_link
    import mac_kbd_pkg::*;
#(
    parameter int HALF_PERIOD  = 1300,
    parameter int RESP_TIMEOUT = 2031250
) (
    input  logic           clk32,
    input  logic           _reset,
    input  logic           clk8_en_p,
    mac_kbd_link_if.master bus
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LIMIT = TW'(RESP_TIMEOUT);
    localparam logic [TW-1:0] TCNT_MAX   = '1;

    kbd_state_t    state;
    logic [2:0]    bitcnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    resp;
    logic          resp_valid;
    logic [7:0]    out_data;
    logic          out_strobe;
    logic          data_q;
    logic          drop_q;

    logic          dat;
    logic          clk_active;
    logic          kbdclk;
    logic          rise_p;
    logic          fall_p;

    // CB2 is open-drain style: released (cb2_t low) reads as high.
    assign dat        = ~bus.cb2_t | bus.cb2_o;
    assign clk_active = (state == ST_CMD_RX) || (state == ST_RESP_TX);

    mac_kbd_clkgen #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_clkgen (
        .clk32     (clk32),
        ._reset    (_reset),
        .clk8_en_p (clk8_en_p),
        .active    (clk_active),
        .kbdclk    (kbdclk),
        .rise_p    (rise_p),
        .fall_p    (fall_p)
    );

    always_ff @(posedge clk32 or negedge _reset) begin
        if (!_reset) begin
            state      <= ST_IDLE;
            bitcnt     <= 3'd0;
            tcnt       <= '0;
            resp       <= 8'h00;
            resp_valid <= 1'b0;
            out_data   <= 8'h00;
            out_strobe <= 1'b0;
            data_q     <= 1'b1;
            drop_q     <= 1'b0;
        end else if (clk8_en_p) begin
            out_strobe <= 1'b0;
            drop_q     <= 1'b0;

            // Translator bytes overwrite the slot until transmission starts; the byte in flight is protected.
            if (bus.kbd_in_strobe) begin
                if (state == ST_RESP_TX) begin
                    drop_q <= 1'b1;
                end else begin
                    resp       <= bus.kbd_in_data;
                    resp_valid <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (!dat) begin
                        state  <= ST_CMD_RX;
                        bitcnt <= 3'd0;
                    end
                end

                ST_CMD_RX: begin
                    if (fall_p) begin
                        out_data <= {out_data[6:0], dat};
                    end
                    if (rise_p) begin
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            out_strobe <= 1'b1;
                            state      <= ST_WAIT_RESP;
                            tcnt       <= '0;
                        end
                    end
                end

                // The Mac may keep CB2 low for a while after the command; only a released line starts the reply.
                ST_WAIT_RESP: begin
                    if (tcnt != TCNT_MAX) begin
                        tcnt <= tcnt + TW'(1);
                    end
                    if (dat) begin
                        if (resp_valid) begin
                            state  <= ST_RESP_TX;
                            bitcnt <= 3'd0;
                        end else if (tcnt >= TCNT_LIMIT) begin
                            resp       <= NULL_RESP;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP_TX;
                            bitcnt     <= 3'd0;
                        end
                    end
                end

                ST_RESP_TX: begin
                    if (fall_p) begin
                        data_q <= resp_bit(resp, bitcnt);
                    end
                    if (rise_p) begin
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            data_q     <= 1'b1;
                            resp_valid <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.kbdclk         = kbdclk;
    assign bus.kbddata_o      = data_q;
    assign bus.kbd_out_data   = out_data;
    assign bus.kbd_out_strobe = out_strobe;
    assign bus.resp_drop      = drop_q;
    assign bus.busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_mac_kbd_link.sv
// Scoreboard bench for mac_kbd_link: a Mac-side driver issues commands and translator
// bytes, a separate monitor decodes the link and compares against queued expectations.
module tb_mac_kbd_link;
    import mac_kbd_pkg::*;

    localparam int HP = 4;
    localparam int RT = 200;

    logic clk32     = 1'b0;
    logic _reset    = 1'b1;
    logic clk8_en_p = 1'b0;
    logic stall     = 1'b0;
    int   divCnt    = 0;
    int   tickNo    = 0;

    int checks   = 0;
    int failures = 0;

    logic [7:0] expCmdQ[$];
    logic [7:0] expRespQ[$];
    int         dropExp  = 0;
    int         dropSeen = 0;

    int         fallCnt    = 0;
    logic       prevKbdclk = 1'b1;
    logic [7:0] rxByte     = 8'h00;

    mac_kbd_link_if bus();

    mac_kbd_link #(
        .HALF_PERIOD  (HP),
        .RESP_TIMEOUT (RT)
    ) dut (
        .clk32     (clk32),
        ._reset    (_reset),
        .clk8_en_p (clk8_en_p),
        .bus       (bus)
    );

    always #15 clk32 = ~clk32;

    // One enable in four clk32 cycles, suppressible to model a stalled 8 MHz domain.
    always @(negedge clk32) begin
        divCnt    = (divCnt == 3) ? 0 : divCnt + 1;
        clk8_en_p = (divCnt == 3) && !stall;
    end

    always @(posedge clk32) begin
        if (clk8_en_p) tickNo++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: consumes strobes the way a tick-driven neighbour would, and decodes reply bits on kbdclk falls.
    always @(negedge clk32) begin
        if (!_reset) begin
            fallCnt    = 0;
            prevKbdclk = 1'b1;
        end else begin
            if (clk8_en_p && bus.kbd_out_strobe) begin
                if (expCmdQ.size() == 0)
                    checkOutput("command strobe without expectation", 32'(expCmdQ.size()), 32'd1);
                else
                    checkOutput("command byte", 32'(bus.kbd_out_data), 32'(expCmdQ.pop_front()));
            end
            if (clk8_en_p && bus.resp_drop) dropSeen++;
            if (prevKbdclk && !bus.kbdclk) begin
                fallCnt++;
                if (fallCnt > 8) begin
                    rxByte = {rxByte[6:0], bus.kbddata_o};
                    if (fallCnt == 16) begin
                        if (expRespQ.size() == 0)
                            checkOutput("response without expectation", 32'(expRespQ.size()), 32'd1);
                        else
                            checkOutput("response byte", 32'(rxByte), 32'(expRespQ.pop_front()));
                    end
                end
            end
            prevKbdclk = bus.kbdclk;
            if (!bus.busy) fallCnt = 0;
        end
    end

    task automatic waitTick();
        do @(posedge clk32); while (!clk8_en_p);
        #1;
    endtask

    task automatic waitKbdclk(input logic level, input string name, input int budget);
        bit seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            waitTick();
            if (bus.kbdclk === level) seen = 1'b1;
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    task automatic driveBit(input logic b);
        if (b) begin
            if ($urandom_range(0, 1) == 1) begin
                bus.cb2_t = 1'b0;
                bus.cb2_o = 1'($urandom_range(0, 1));
            end else begin
                bus.cb2_t = 1'b1;
                bus.cb2_o = 1'b1;
            end
        end else begin
            bus.cb2_t = 1'b1;
            bus.cb2_o = 1'b0;
        end
    endtask

    task automatic stallCheck();
        logic [11:0] snap;
        bit          same = 1'b1;
        stall = 1'b1;
        snap  = {bus.kbdclk, bus.kbddata_o, bus.busy, bus.kbd_out_strobe, bus.kbd_out_data};
        repeat (100) begin
            @(posedge clk32);
            #1;
            if ({bus.kbdclk, bus.kbddata_o, bus.busy, bus.kbd_out_strobe, bus.kbd_out_data} !== snap)
                same = 1'b0;
        end
        checkOutput("outputs frozen while clk8_en_p low", 32'(same), 32'd1);
        stall = 1'b0;
    endtask

    task automatic sendCommand(input logic [7:0] cmd, input int stallAfter, input int abortAfter,
                               output int entryTick, output int lastRise);
        bit started = 1'b0;
        entryTick = 0;
        lastRise  = 0;
        bus.cb2_t = 1'b1;
        bus.cb2_o = 1'b0;
        for (int t = 0; t < 8 && !started; t++) begin
            waitTick();
            if (bus.busy === 1'b1) begin
                started   = 1'b1;
                entryTick = tickNo;
            end
        end
        checkOutput("frame start raises busy", 32'(started), 32'd1);
        for (int i = 7; i >= 0; i--) begin
            driveBit(cmd[i]);
            waitKbdclk(1'b0, "command falling edge", 4 * HP + 4);
            waitKbdclk(1'b1, "command rising edge", 4 * HP + 4);
            lastRise = tickNo;
            if (8 - i == abortAfter) return;
            if (8 - i == stallAfter) stallCheck();
        end
        bus.cb2_t = 1'b1;
        bus.cb2_o = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] cmd, input int nStrobes, input logic [7:0] first,
                                 input logic [7:0] second, input int holdTicks, input bit dropMid,
                                 input bit checkTiming, input int stallAfter);
        int         entryTick;
        int         lastRise;
        int         delay;
        bit         idle = 1'b0;
        logic [7:0] expResp = NULL_RESP;

        expCmdQ.push_back(cmd);
        sendCommand(cmd, stallAfter, 0, entryTick, lastRise);
        checkOutput("command frame length in ticks", 32'(lastRise - entryTick), 32'(16 * HP));

        for (int s = 0; s < nStrobes; s++) begin
            expResp           = (s == 0) ? first : second;
            bus.kbd_in_data   = expResp;
            bus.kbd_in_strobe = 1'b1;
            waitTick();
            bus.kbd_in_strobe = 1'b0;
        end
        expRespQ.push_back(expResp);

        repeat (holdTicks) waitTick();
        bus.cb2_t = 1'b0;
        bus.cb2_o = 1'b1;

        if (checkTiming || dropMid) begin
            waitKbdclk(1'b0, "first response falling edge", RT + 8 * HP);
            delay = tickNo - lastRise;
            if (checkTiming)
                checkOutput("NULL reply starts about RT ticks after WAIT_RESP entry",
                            32'(delay >= RT + HP && delay <= RT + HP + 2), 32'd1);
            if (dropMid) begin
                bus.kbd_in_data   = 8'($urandom);
                bus.kbd_in_strobe = 1'b1;
                dropExp++;
                waitTick();
                bus.kbd_in_strobe = 1'b0;
            end
        end

        for (int t = 0; t < 4 * RT && !idle; t++) begin
            waitTick();
            if (bus.busy === 1'b0) idle = 1'b1;
        end
        checkOutput("frame returns to idle", 32'(idle), 32'd1);
        checkOutput("data line idles high", 32'(bus.kbddata_o), 32'd1);
        checkOutput("clock idles high", 32'(bus.kbdclk), 32'd1);
    endtask

    initial begin
        #2_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         e;
        int         r;
        logic [7:0] rc;
        logic [7:0] ra;
        logic [7:0] rb;

        bus.cb2_t         = 1'b0;
        bus.cb2_o         = 1'b1;
        bus.kbd_in_data   = 8'h00;
        bus.kbd_in_strobe = 1'b0;
        #5;
        _reset = 1'b0;
        repeat (5) @(posedge clk32);
        #1;
        checkOutput("reset kbdclk", 32'(bus.kbdclk), 32'd1);
        checkOutput("reset kbddata_o", 32'(bus.kbddata_o), 32'd1);
        checkOutput("reset kbd_out_data", 32'(bus.kbd_out_data), 32'd0);
        checkOutput("reset kbd_out_strobe", 32'(bus.kbd_out_strobe), 32'd0);
        checkOutput("reset resp_drop", 32'(bus.resp_drop), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        _reset = 1'b1;
        repeat (3) waitTick();

        applyStimulus(INQUIRY, 1, 8'h3C, 8'h00, 5, 1'b0, 1'b0, -1);
        applyStimulus(8'h14, 1, 8'hA5, 8'h00, 10, 1'b0, 1'b0, -1);
        applyStimulus(8'h36, 0, 8'h00, 8'h00, 0, 1'b0, 1'b1, -1);
        applyStimulus(8'h77, 2, 8'h11, 8'h22, 3, 1'b1, 1'b0, -1);

        sendCommand(8'h5A, -1, 4, e, r);
        _reset = 1'b0;
        #1;
        checkOutput("abort kbdclk high", 32'(bus.kbdclk), 32'd1);
        checkOutput("abort kbddata_o high", 32'(bus.kbddata_o), 32'd1);
        checkOutput("abort busy low", 32'(bus.busy), 32'd0);
        bus.cb2_t = 1'b0;
        bus.cb2_o = 1'b1;
        repeat (6) @(posedge clk32);
        #1;
        _reset = 1'b1;
        checkOutput("abort kbd_out_data cleared", 32'(bus.kbd_out_data), 32'd0);
        repeat (10) waitTick();
        applyStimulus(INQUIRY, 1, 8'hC3, 8'h00, 2, 1'b0, 1'b0, -1);

        applyStimulus(8'hB2, 1, 8'h4E, 8'h00, 4, 1'b0, 1'b0, 3);
        applyStimulus(8'h16, 0, 8'h00, 8'h00, RT + 50, 1'b0, 1'b0, -1);

        for (int f = 0; f < 8; f++) begin
            rc = 8'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(rc, $urandom_range(0, 2), ra, rb, $urandom_range(0, 40),
                          1'($urandom_range(0, 1)), 1'b0, -1);
        end

        repeat (10) waitTick();
        checkOutput("all command expectations consumed", 32'(expCmdQ.size()), 32'd0);
        checkOutput("all response expectations consumed", 32'(expRespQ.size()), 32'd0);
        checkOutput("resp_drop pulse count", 32'(dropSeen), 32'(dropExp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
